// File: rtl/cpu_jtag_debug_ocimem_pkg.sv
// Shared definitions for the JTAG debug on-chip memory block.
//   - state_t       : arbitration / access FSM states
//   - jdo field positions decoded from the JTAG sysclk payload
//   - REG_OFFSET    : word offset of the monitor flag register in the
//                     CPU register space (avs_address MSB = 1)
package cpu_jtag_debug_ocimem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_J_RD     = 3'd1,
    ST_J_RD_CAP = 3'd2,
    ST_J_WR     = 3'd3,
    ST_C_RD_CAP = 3'd4
  } state_t;

  localparam int ADDR_LSB   = 17;  // jdo: start of the debugger address field
  localparam int RD_FLAG    = 35;  // jdo: ocimem_a requests a read at the new address
  localparam int CLR_RDY    = 34;  // jdo: ocimem_a clears monitor_ready
  localparam int DATA_LSB   = 3;   // jdo: start of the 32-bit write data field
  localparam int DATA_W     = 32;
  localparam int REG_OFFSET = 0;   // monitor flag register offset

endpackage

// File: rtl/cpu_jtag_debug_ocimem_ram.sv
// Single-port 2**ADDR_W x 32 debug RAM with byte enables.
// Read is registered: o_rdata holds mem[i_addr] one clock after i_addr is
// presented (read-before-write on a same-address write).
// Ports:
//   i_clk    clock
//   i_addr   word address
//   i_we     write enable
//   i_be     byte lane enables for the write
//   i_wdata  write data
//   o_rdata  registered read data
module cpu_jtag_debug_ocimem_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_we,
  input  logic [3:0]        i_be,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [2**ADDR_W];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
    o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/cpu_jtag_debug_ocimem.sv
// JTAG debugger access to the on-chip debug RAM, arbitrated against the
// CPU's Avalon-MM debug slave.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   jdo                      command payload, valid with a strobe
//   take_action_ocimem_a     load MonAReg, optional read / ready clear
//   take_action_ocimem_b     load MonDReg and write it at MonAReg
//   take_no_action_ocimem_a  read at MonAReg
//   avs_*                    CPU slave port (address MSB selects registers)
//   MonDReg, MonAReg         debugger data / address registers
//   monitor_ready/_error     monitor handshake flags
//   cmd_overrun              sticky: a strobe arrived while busy
//   o_dbg_state              current FSM state
//
// Handshake: a CPU transfer completes on a clock edge where avs_waitrequest
// is 0; the master holds address/data/command stable until then. Writes
// complete in IDLE with no JTAG strobe present; reads are accepted in IDLE
// and return data in C_RD_CAP with waitrequest low. JTAG strobes are single
// cycle and are only acted on in IDLE; anywhere else they are dropped.
module cpu_jtag_debug_ocimem
  import cpu_jtag_debug_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int JDO_W  = 38
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W:0]   avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic [31:0]       MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic              cmd_overrun,
  output state_t            o_dbg_state
);

  state_t            r_state, w_next;
  logic [31:0]       r_mon_d, r_wdata, r_reg_rd;
  logic [ADDR_W-1:0] r_mon_a;
  logic              r_ready, r_error, r_overrun, r_cpu_reg_sel;

  logic              w_strobe, w_idle, w_cpu_wr_ok, w_cpu_rd_ok, w_reg_hit;
  logic [ADDR_W-1:0] w_ram_addr;
  logic              w_ram_we;
  logic [3:0]        w_ram_be;
  logic [31:0]       w_ram_wdata, w_ram_rdata;
  logic              w_unused;

  assign w_unused    = ^{jdo[DATA_LSB-1:0], jdo[JDO_W-1:RD_FLAG+1]};

  assign w_strobe    = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign w_idle      = (r_state == ST_IDLE);
  // Any JTAG strobe in IDLE takes the cycle, so the CPU is stalled.
  assign w_cpu_wr_ok = w_idle & ~w_strobe & avs_write & ~avs_read;
  assign w_cpu_rd_ok = w_idle & ~w_strobe & avs_read;
  assign w_reg_hit   = (avs_address[ADDR_W-1:0] == ADDR_W'(REG_OFFSET));

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (take_action_ocimem_b)         w_next = ST_J_WR;
        else if (take_action_ocimem_a)    w_next = jdo[RD_FLAG] ? ST_J_RD : ST_IDLE;
        else if (take_no_action_ocimem_a) w_next = ST_J_RD;
        else if (avs_read)                w_next = ST_C_RD_CAP;
      end
      ST_J_RD:     w_next = ST_J_RD_CAP;
      ST_J_RD_CAP: w_next = ST_IDLE;
      ST_J_WR:     w_next = ST_IDLE;
      ST_C_RD_CAP: w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  // RAM port mux: JTAG owns the port in J_RD/J_WR, the CPU otherwise.
  // Writes are suppressed during reset so an in-flight access is abandoned.
  always_comb begin
    w_ram_addr  = avs_address[ADDR_W-1:0];
    w_ram_we    = w_cpu_wr_ok & ~avs_address[ADDR_W] & ~reset;
    w_ram_be    = avs_byteenable;
    w_ram_wdata = avs_writedata;
    if (r_state == ST_J_RD) begin
      w_ram_addr = r_mon_a;
      w_ram_we   = 1'b0;
    end else if (r_state == ST_J_WR) begin
      w_ram_addr  = r_mon_a;
      w_ram_we    = ~reset;
      w_ram_be    = 4'hF;
      w_ram_wdata = r_wdata;
    end
  end

  cpu_jtag_debug_ocimem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .i_clk   (clk),
    .i_addr  (w_ram_addr),
    .i_we    (w_ram_we),
    .i_be    (w_ram_be),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_mon_d       <= '0;
      r_mon_a       <= '0;
      r_wdata       <= '0;
      r_reg_rd      <= '0;
      r_ready       <= 1'b0;
      r_error       <= 1'b0;
      r_overrun     <= 1'b0;
      r_cpu_reg_sel <= 1'b0;
    end else begin
      r_state <= w_next;
      if (!w_idle && w_strobe) r_overrun <= 1'b1;
      if (w_idle) begin
        if (take_action_ocimem_b) begin
          r_mon_d <= jdo[DATA_LSB +: DATA_W];
          r_wdata <= jdo[DATA_LSB +: DATA_W];
        end else if (take_action_ocimem_a) begin
          r_mon_a <= jdo[ADDR_LSB +: ADDR_W];
          if (jdo[CLR_RDY]) r_ready <= 1'b0;
        end
        if (w_cpu_rd_ok) begin
          r_cpu_reg_sel <= avs_address[ADDR_W];
          r_reg_rd      <= w_reg_hit ? {30'b0, r_error, r_ready} : 32'b0;
        end
        if (w_cpu_wr_ok && avs_address[ADDR_W] && w_reg_hit) begin
          r_ready <= avs_writedata[0];
          r_error <= avs_writedata[1];
        end
      end
      // Address advances once the RAM access at the old address is issued.
      if (r_state == ST_J_WR || r_state == ST_J_RD) r_mon_a <= r_mon_a + 1'b1;
      if (r_state == ST_J_RD_CAP) r_mon_d <= w_ram_rdata;
    end
  end

  assign avs_waitrequest = reset | ~((r_state == ST_C_RD_CAP) | w_cpu_wr_ok);
  assign avs_readdata    = (!reset && r_state == ST_C_RD_CAP) ?
                           (r_cpu_reg_sel ? r_reg_rd : w_ram_rdata) : 32'b0;
  assign MonDReg         = reset ? 32'b0 : r_mon_d;
  assign MonAReg         = reset ? '0 : r_mon_a;
  assign monitor_ready   = ~reset & r_ready;
  assign monitor_error   = ~reset & r_error;
  assign cmd_overrun     = ~reset & r_overrun;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_cpu_jtag_debug_ocimem.sv
module tb_cpu_jtag_debug_ocimem;
  import cpu_jtag_debug_ocimem_pkg::*;

  localparam int ADDR_W = 8;
  localparam int JDO_W  = 38;
  localparam int DEPTH  = 2**ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic [JDO_W-1:0]  jdo;
  logic              take_a, take_b, take_n;
  logic [ADDR_W:0]   avs_address;
  logic              avs_read, avs_write;
  logic [31:0]       avs_writedata;
  logic [3:0]        avs_byteenable;
  logic [31:0]       avs_readdata;
  logic              avs_waitrequest;
  logic [31:0]       mon_d;
  logic [ADDR_W-1:0] mon_a;
  logic              mon_rdy, mon_err, ovr;
  state_t            dbg_state;

  cpu_jtag_debug_ocimem #(.ADDR_W(ADDR_W), .JDO_W(JDO_W)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_a),
    .take_action_ocimem_b    (take_b),
    .take_no_action_ocimem_a (take_n),
    .avs_address             (avs_address),
    .avs_read                (avs_read),
    .avs_write               (avs_write),
    .avs_writedata           (avs_writedata),
    .avs_byteenable          (avs_byteenable),
    .avs_readdata            (avs_readdata),
    .avs_waitrequest         (avs_waitrequest),
    .MonDReg                 (mon_d),
    .MonAReg                 (mon_a),
    .monitor_ready           (mon_rdy),
    .monitor_error           (mon_err),
    .cmd_overrun             (ovr),
    .o_dbg_state             (dbg_state)
  );

  // Clock / timeout
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Behavioural reference state
  logic [31:0]       m_mem [DEPTH];
  logic [31:0]       m_d;
  logic [ADDR_W-1:0] m_a;
  logic              m_rdy, m_err, m_ovr;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".MonDReg"}, mon_d, m_d);
    check({tag, ".MonAReg"}, {24'b0, mon_a}, {24'b0, m_a});
    check({tag, ".ready"},   {31'b0, mon_rdy}, {31'b0, m_rdy});
    check({tag, ".error"},   {31'b0, mon_err}, {31'b0, m_err});
    check({tag, ".overrun"}, {31'b0, ovr}, {31'b0, m_ovr});
  endtask

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_d = '0; m_a = '0; m_rdy = 1'b0; m_err = 1'b0; m_ovr = 1'b0;
  endtask

  function automatic logic [31:0] reg_value(input logic [ADDR_W-1:0] off);
    return (off == 0) ? {30'b0, m_err, m_rdy} : 32'b0;
  endfunction

  task automatic jtag_a(input logic [ADDR_W-1:0] addr, input logic rd, input logic clr);
    jdo = JDO_W'({$urandom, $urandom});
    jdo[ADDR_LSB +: ADDR_W] = addr;
    jdo[RD_FLAG] = rd;
    jdo[CLR_RDY] = clr;
    take_a = 1'b1;
    tick();
    take_a = 1'b0;
    m_a = addr;
    if (clr) m_rdy = 1'b0;
    if (rd) begin
      tick(); tick();
      m_d = m_mem[m_a];
      m_a = m_a + 1'b1;
    end
  endtask

  task automatic jtag_b(input logic [31:0] data);
    jdo = JDO_W'({$urandom, $urandom});
    jdo[DATA_LSB +: 32] = data;
    take_b = 1'b1;
    tick();
    take_b = 1'b0;
    tick();
    m_mem[m_a] = data;
    m_d = data;
    m_a = m_a + 1'b1;
  endtask

  task automatic jtag_n();
    take_n = 1'b1;
    tick();
    take_n = 1'b0;
    tick(); tick();
    m_d = m_mem[m_a];
    m_a = m_a + 1'b1;
  endtask

  task automatic cpu_write(input logic [ADDR_W:0] addr, input logic [31:0] data, input logic [3:0] be);
    logic done;
    done = 1'b0;
    avs_address = addr; avs_writedata = data; avs_byteenable = be; avs_write = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (!avs_waitrequest) done = 1'b1;
      tick();
    end
    avs_write = 1'b0;
    if (!done) check("cpu_write_done", {31'b0, done}, 32'd1);
    if (addr[ADDR_W]) begin
      if (addr[ADDR_W-1:0] == 0) begin
        m_rdy = data[0];
        m_err = data[1];
      end
    end else begin
      for (int b = 0; b < 4; b++)
        if (be[b]) m_mem[addr[ADDR_W-1:0]][8*b +: 8] = data[8*b +: 8];
    end
  endtask

  task automatic cpu_read(input logic [ADDR_W:0] addr, output logic [31:0] data, output int waits);
    logic done;
    done = 1'b0; waits = 0; data = 'x;
    avs_address = addr; avs_read = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (!avs_waitrequest) begin
        done = 1'b1;
        data = avs_readdata;
      end else begin
        waits++;
      end
      tick();
    end
    avs_read = 1'b0;
    if (!done) check("cpu_read_done", {31'b0, done}, 32'd1);
  endtask

  task automatic cpu_read_check(input string tag, input logic [ADDR_W:0] addr);
    logic [31:0] d;
    logic [31:0] exp;
    int w;
    exp = addr[ADDR_W] ? reg_value(addr[ADDR_W-1:0]) : m_mem[addr[ADDR_W-1:0]];
    cpu_read(addr, d, w);
    check(tag, d, exp);
  endtask

  // Stimulus
  initial begin
    logic [31:0] d;
    logic [31:0] jtag_seen;
    int          waits;
    logic        done;

    reset = 1'b1;
    jdo = '0; take_a = 0; take_b = 0; take_n = 0;
    avs_address = '0; avs_read = 0; avs_write = 0; avs_writedata = '0; avs_byteenable = '0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 'x;
    model_reset();

    // Reset behaviour
    tick();
    @(negedge clk);
    check("reset_waitrequest", {31'b0, avs_waitrequest}, 32'd1);
    check("reset_readdata", avs_readdata, 32'd0);
    tick();
    reset = 1'b0;
    check_regs("after_reset");

    // Fill the RAM through the CPU port so every word is known.
    for (int i = 0; i < DEPTH; i++) cpu_write({1'b0, ADDR_W'(i)}, $urandom, 4'hF);

    // Address load without read
    jtag_a(8'h10, 1'b0, 1'b0);
    check_regs("load_addr");

    // Three writes spaced 4 cycles
    for (int i = 1; i <= 3; i++) begin
      jtag_b(32'hA5A5_0000 + i);
      tick(); tick();
    end
    check_regs("three_writes");
    cpu_read_check("ram_0x10", 9'h010);
    cpu_read_check("ram_0x11", 9'h011);
    cpu_read_check("ram_0x12", 9'h012);

    // Read latency after ocimem_a with read
    jdo = '0;
    jdo[ADDR_LSB +: ADDR_W] = 8'h10;
    jdo[RD_FLAG] = 1'b1;
    take_a = 1'b1;
    tick();
    take_a = 1'b0;
    check("rd_lat_addr_p1", {24'b0, mon_a}, 32'h10);
    tick();
    check("rd_lat_data_p2", mon_d, 32'hA5A5_0003);
    tick();
    check("rd_lat_data_p3", mon_d, 32'hA5A5_0001);
    check("rd_lat_addr_p3", {24'b0, mon_a}, 32'h11);
    m_a = 8'h11; m_d = 32'hA5A5_0001;

    // Address wrap
    jtag_a(8'hFF, 1'b0, 1'b0);
    jtag_b(32'hDEAD_BEEF);
    check_regs("wrap");
    cpu_read_check("ram_0xff", 9'h0FF);

    // JTAG read and CPU read in the same cycle: JTAG wins
    jtag_a(8'h10, 1'b0, 1'b0);
    take_n = 1'b1;
    avs_address = 9'h011; avs_read = 1'b1;
    done = 1'b0; waits = 0; d = '0; jtag_seen = '0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (!avs_waitrequest) begin
        done = 1'b1;
        d = avs_readdata;
        jtag_seen = mon_d;
      end else begin
        waits++;
      end
      tick();
      take_n = 1'b0;
    end
    avs_read = 1'b0;
    m_d = m_mem[8'h10]; m_a = 8'h11;
    check("arb_done", {31'b0, done}, 32'd1);
    check("arb_stall_ge3", {31'b0, (waits >= 3)}, 32'd1);
    check("arb_cpu_data", d, m_mem[8'h11]);
    check("arb_jtag_first", jtag_seen, m_mem[8'h10]);
    check_regs("arb");

    // Overrun: second strobe while busy is dropped
    take_n = 1'b1;
    tick();
    take_n = 1'b0;
    jdo = '0;
    jdo[DATA_LSB +: 32] = 32'h1234_5678;
    take_b = 1'b1;
    tick();
    take_b = 1'b0;
    tick();
    m_d = m_mem[m_a]; m_a = m_a + 1'b1; m_ovr = 1'b1;
    check_regs("overrun");
    cpu_read_check("overrun_ram_prev", {1'b0, m_a - 8'd1});
    cpu_read_check("overrun_ram_cur", {1'b0, m_a});

    // Register space
    cpu_write(9'h100, 32'h3, 4'hF);
    check_regs("reg_set");
    cpu_read_check("reg_read_3", 9'h100);
    jtag_a(8'h20, 1'b0, 1'b1);
    check_regs("reg_clear_ready");
    cpu_read_check("reg_read_2", 9'h100);
    cpu_read_check("reg_read_other", 9'h105);

    // Randomised mix checked against the reference
    for (int it = 0; it < 120; it++) begin
      case ($urandom_range(0, 4))
        0: begin
          jtag_a(ADDR_W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
          check_regs("rnd_a");
        end
        1: begin
          jtag_b($urandom);
          check_regs("rnd_b");
        end
        2: begin
          jtag_n();
          check_regs("rnd_n");
        end
        3: begin
          if ($urandom_range(0, 7) == 0)
            cpu_write({1'b1, ADDR_W'($urandom_range(0, 1))}, $urandom, 4'hF);
          else
            cpu_write({1'b0, ADDR_W'($urandom)}, $urandom, 4'($urandom_range(0, 15)));
          check_regs("rnd_cpu_wr");
        end
        default: begin
          if ($urandom_range(0, 5) == 0)
            cpu_read_check("rnd_cpu_rd_reg", {1'b1, ADDR_W'($urandom_range(0, 1))});
          else
            cpu_read_check("rnd_cpu_rd_ram", {1'b0, ADDR_W'($urandom)});
        end
      endcase
    end

    // Reset in the middle of a JTAG read
    take_n = 1'b1;
    tick();
    take_n = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("midrd_reset_wait", {31'b0, avs_waitrequest}, 32'd1);
    check("midrd_reset_mond", mon_d, 32'd0);
    tick();
    reset = 1'b0;
    model_reset();
    check_regs("midrd_after_reset");
    check("midrd_state", {29'b0, dbg_state}, {29'b0, ST_IDLE});
    tick(); tick(); tick();
    check_regs("midrd_settled");
    cpu_read_check("ram_kept_0x11", 9'h011);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
